// File: rtl/image_buffer_writer.sv
// image_buffer_writer: loads a ROWSxCOLS image from a valid/ready pixel stream into RAM with (x,y) random read
module image_buffer_writer #(
  parameter int ROWS = 10,
  parameter int COLS = 12,
  parameter int DW = 4,
  parameter int MAX_PIX = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [3:0]    rd_x,
  input  logic [3:0]    rd_y,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          image_valid,
  output logic          err_pixel,
  output logic [6:0]    wr_count
);
  localparam int AW = $clog2(ROWS * COLS);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, nxt;
  logic [3:0] x, y;
  logic [DW-1:0] mem [ROWS*COLS];
  logic [AW-1:0] wa, ra;
  logic hs, legal, last, y_end, rd_ok;
  assign in_ready = state == LOAD;
  assign busy = state == LOAD;
  assign image_valid = state == DONE;
  assign hs = in_valid && in_ready && !start;
  assign legal = in_data <= DW'(MAX_PIX);
  assign y_end = y == 4'(COLS - 1);
  assign last = x == 4'(ROWS - 1) && y_end;
  assign wa = AW'(x * COLS + y);
  assign ra = AW'(rd_x * COLS + rd_y);
  assign rd_ok = rd_x < 4'(ROWS) && rd_y < 4'(COLS);
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // next state: start wins from anywhere, last legal pixel finishes the load
  always_comb begin
    nxt = state;
    nxt = start ? LOAD :
          state == LOAD && hs && legal && last ? DONE : state;
  end
  // write counters and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      wr_count <= '0;
      done <= 1'b0;
      err_pixel <= 1'b0;
    end else begin
      done <= hs && legal && last;
      err_pixel <= hs && !legal;
      if (start) begin
        x <= '0;
        y <= '0;
        wr_count <= '0;
      end else if (hs && legal) begin
        y <= y_end ? '0 : y + 4'd1;
        x <= last ? '0 : y_end ? x + 4'd1 : x;
        wr_count <= wr_count + 7'd1;
      end
    end
  end
  // pixel RAM, never cleared so a partial load survives reset
  always_ff @(posedge clk)
    if (hs && legal) mem[wa] <= in_data;
  // registered read port, out-of-range coordinates read as zero
  always_ff @(posedge clk)
    rd_data <= rst || !rd_ok ? '0 : mem[ra];
endmodule

// File: tb/tb_image_buffer_writer.sv
// tb_image_buffer_writer: directed self-checking bench for image_buffer_writer
module tb_image_buffer_writer;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, busy, done, image_valid, err_pixel;
  logic [3:0] in_data, rd_x, rd_y, rd_data;
  logic [6:0] wr_count;
  int errors = 0, checks = 0, widx = 0;
  int mdl [120];
  logic seen_err, seen_done;
  int old;

  always #5 clk = ~clk;

  image_buffer_writer dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .busy(busy),
    .done(done), .image_valid(image_valid), .err_pixel(err_pixel), .wr_count(wr_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int v);
    in_valid = 1'b1;
    in_data = 4'(v);
    tick;
    in_valid = 1'b0;
    if (v <= 9) begin
      mdl[widx] = v;
      widx++;
    end
  endtask

  task automatic go;
    start = 1'b1;
    tick;
    start = 1'b0;
    widx = 0;
  endtask

  task automatic rd(input string tag, input int x, input int y, input int exp);
    rd_x = 4'(x);
    rd_y = 4'(y);
    tick;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic rd_all(input string tag);
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 12; y++)
        rd(tag, x, y, mdl[x*12+y]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_x = '0; rd_y = '0;
    tick;
    tick;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_image_valid", 32'(image_valid), 0);
    chk("rst_err", 32'(err_pixel), 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;
    tick;
    chk("idle_in_ready", 32'(in_ready), 0);

    go;
    chk("load_busy", 32'(busy), 1);
    for (int i = 0; i < 120; i++) begin
      chk("b2b_in_ready", 32'(in_ready), 1);
      push(i % 10);
    end
    chk("b2b_done", 32'(done), 1);
    chk("b2b_image_valid", 32'(image_valid), 1);
    chk("b2b_wr_count", 32'(wr_count), 120);
    chk("b2b_in_ready_off", 32'(in_ready), 0);
    tick;
    chk("b2b_done_pulse", 32'(done), 0);
    rd("rd_3_5", 3, 5, 1);
    rd("rd_9_11", 9, 11, 9);

    go;
    seen_err = 1'b0;
    seen_done = 1'b0;
    for (int n = 0; n < 3000 && widx < 120; n++) begin
      if ($urandom_range(0, 2) != 0) push((widx + 3) % 10);
      else begin
        in_valid = 1'b0;
        in_data = 4'd15;
        tick;
      end
      seen_err |= err_pixel;
      if (widx < 120) seen_done |= done;
    end
    chk("rnd_done", 32'(done), 1);
    chk("rnd_early_done", 32'(seen_done), 0);
    chk("rnd_no_err", 32'(seen_err), 0);
    rd_all("rnd_mem");
    in_valid = 1'b1;
    in_data = 4'd5;
    tick;
    tick;
    in_valid = 1'b0;
    chk("done_ignore_wr_count", 32'(wr_count), 120);
    chk("done_ignore_err", 32'(err_pixel), 0);
    rd("done_ignore_mem", 0, 0, mdl[0]);

    go;
    chk("restart_image_valid", 32'(image_valid), 0);
    chk("restart_wr_count", 32'(wr_count), 0);
    for (int i = 0; i < 50; i++) push(i % 10);
    push(12);
    chk("bad_err", 32'(err_pixel), 1);
    chk("bad_wr_count", 32'(wr_count), 50);
    push(7);
    chk("bad_err_pulse", 32'(err_pixel), 0);
    chk("after_bad_wr_count", 32'(wr_count), 51);
    while (widx < 60) push(widx % 10);
    rd("rd_4_2", 4, 2, 7);
    chk("mid_wr_count", 32'(wr_count), 60);
    in_valid = 1'b1;
    in_data = 4'd8;
    go;
    in_valid = 1'b0;
    chk("mid_start_wr_count", 32'(wr_count), 0);
    chk("mid_start_image_valid", 32'(image_valid), 0);
    chk("mid_start_busy", 32'(busy), 1);
    rd("start_hs_ignored", 0, 0, mdl[0]);
    for (int i = 0; i < 120; i++) begin
      if (i == 31) begin
        rd_x = 4'd2;
        rd_y = 4'd7;
        old = mdl[31];
      end
      push((i * 3 + 1) % 10);
      if (i == 31) chk("rw_old", 32'(rd_data), 32'(old));
      if (i == 32) chk("rw_new", 32'(rd_data), 32'(mdl[31]));
    end
    chk("reload_done", 32'(done), 1);
    chk("reload_wr_count", 32'(wr_count), 120);
    chk("reload_image_valid", 32'(image_valid), 1);
    rd_all("reload_mem");

    go;
    for (int i = 0; i < 30; i++) push((i + 5) % 10);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd2;
    tick;
    rst = 1'b0;
    tick;
    chk("rst_mid_in_ready", 32'(in_ready), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_image_valid", 32'(image_valid), 0);
    chk("rst_mid_wr_count", 32'(wr_count), 0);
    tick;
    chk("idle_ignore_wr_count", 32'(wr_count), 0);
    chk("idle_ignore_err", 32'(err_pixel), 0);
    in_valid = 1'b0;
    rd("partial_kept", 2, 5, mdl[29]);
    go;
    push(6);
    chk("after_rst_wr_count", 32'(wr_count), 1);
    rd("after_rst_0_0", 0, 0, 6);

    rd("oor_x", 10, 0, 0);
    rd("rd_0_0_again", 0, 0, 6);
    rd("oor_y", 0, 12, 0);
    rd("rd_0_0_third", 0, 0, 6);
    rd("oor_xy", 15, 15, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
